fp_mul_scheduler: RTL
=====================

// Module: fp_mul_scheduler
// PURPOSE
//  Shares one pipelined FP_MULTIPLIER (IEEE-754 single) among NUM_REQ requesters.
//  Round-robin arbitration issues at most one operand pair per cycle into the multiplier.
//  A tag pipeline tracks each result; a credit-checked response FIFO absorbs results,
//  because the multiplier pipeline cannot stall. Sits between client datapaths and FP_MULTIPLIER.
// PARAMETERS
//  NUM_REQ      4  number of requesters (>=2); ID_W = $clog2(NUM_REQ) (localparam)
//  MUL_LATENCY  1  clock edges from mul_a/mul_b valid to matching mul_p valid (>=1)
//  RESP_DEPTH   4  response FIFO depth, which is also the max outstanding ops (power of 2, >=2)
// PORTS
//  clk         in   1            single clock, rising edge
//  rst         in   1            asynchronous reset, active-low
//  req_valid   in   NUM_REQ      per-requester operand valid
//  req_a       in   32*NUM_REQ   operand A, requester i in bits [32*i+31:32*i]
//  req_b       in   32*NUM_REQ   operand B, same packing
//  req_ready   out  NUM_REQ      one-hot grant; handshake = req_valid[i] & req_ready[i]
//  mul_a       out  32           registered operand A to FP_MULTIPLIER
//  mul_b       out  32           registered operand B to FP_MULTIPLIER
//  mul_p       in   32           product from FP_MULTIPLIER
//  resp_valid  out  1            response FIFO head valid
//  resp_ready  in   1            consumer accepts head
//  resp_p      out  32           product at FIFO head (0 when empty)
//  resp_id     out  ID_W         originating requester of head (0 when empty)
//  busy        out  1            outstanding != 0
// BEHAVIOUR
//  Reset (rst low, async): req_ready=0, mul_a=mul_b=0, resp_valid=0, resp_p=0, resp_id=0, busy=0.
//    Also clears the RR pointer (to 0), tag pipeline, FIFO and outstanding counter.
//    Reset mid-operation drops all in-flight ops; no stale response may appear after release.
//  outstanding: ops issued but not yet popped (in-flight + FIFO count), range 0..RESP_DEPTH.
//    +1 on issue, -1 on pop (resp_valid&resp_ready); both in the same cycle = unchanged.
//  credit = (outstanding < RESP_DEPTH) | (resp_valid & resp_ready).
//  req_ready is combinational from req_valid, the RR pointer, credit and resp_ready.
//    Exactly one bit is set when credit=1 and any req_valid=1; otherwise all bits are 0.
//  RR arbitration: search starts at ptr, wraps NUM_REQ-1 -> 0.
//    On grant g, ptr <= (g+1) mod NUM_REQ. ptr holds when there is no issue.
//  Issue at edge T: mul_a/mul_b <= operands of g; tag {1,g} enters the tag pipeline.
//    Tag pipeline length = MUL_LATENCY+1, so the tag emerges aligned with mul_p for that op.
//    mul_a/mul_b hold their last value when idle.
//  Writeback: an emerging valid tag writes {mul_p, id} into the FIFO at edge T+MUL_LATENCY+1.
//    resp_valid rises after that edge, so response latency is MUL_LATENCY+2 cycles with an empty FIFO.
//    The credit rule guarantees a FIFO write never meets a full FIFO; an overflow is a bug (assertion).
//  FIFO: in-order, registered head; same-cycle write and pop are allowed at any occupancy.
//    Head updates on the edge after a pop.
//  Results are returned in issue order; there is no reordering per requester.
//  Arithmetic is entirely in FP_MULTIPLIER; this block never modifies operands or products.
// TESTING
//  1 Only req0 valid: A=0x40F00000 (7.5), B=0x40500000 (3.25), resp_ready=1
//    -> resp_p=0x41C30000, resp_id=0, resp_valid high exactly MUL_LATENCY+2 cycles after the handshake.
//  2 req2 only: A=0xC0400000, B=0x40200000 -> resp_p=0xC0F00000, resp_id=2.
//    req1: A=0xBF800000, B=0x3F800000 -> resp_p=0xBF800000, resp_id=1.
//  3 All 4 valid continuously, resp_ready=1 -> grants 0,1,2,3,0,1,... one per cycle, no bubbles.
//    resp_id follows the same sequence.
//  4 All valid, resp_ready=0 -> exactly RESP_DEPTH=4 issues, then req_ready=0, busy=1.
//    Raise resp_ready -> the first pop cycle also issues (credit via pop).
//    Throughput returns to 1/cycle with no lost or duplicated responses.
//  5 Assert rst low with 3 ops in flight and 1 in the FIFO -> resp_valid=0 immediately.
//    After release: no responses until a new issue, first grant goes to req0, busy=0.
//  6 Random valid/resp_ready for 2000 cycles with a reference-model scoreboard.
//    -> every issued op is returned once, in order, with a bit-exact product; outstanding <= 4 always.

Source files
------------

// File: rtl/fp_mul_scheduler.sv
// fp_mul_scheduler
//   Lets NUM_REQ requesters share one pipelined IEEE-754 single-precision
//   multiplier. A round-robin arbiter issues at most one operand pair per cycle.
//   A tag pipeline follows every product through the multiplier. Because the
//   multiplier cannot stall, results land in a response FIFO, and issue is
//   throttled by a credit count of outstanding operations.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active low
//   req_valid  : per-requester operand valid
//   req_a/b    : packed operands, requester i in bits [32*i+31:32*i]
//   req_ready  : one-hot grant (handshake = req_valid & req_ready)
//   mul_a/b    : registered operands to the multiplier
//   mul_p      : product from the multiplier, MUL_LATENCY edges after mul_a/b
//   resp_valid : response FIFO head valid
//   resp_ready : consumer accepts the head
//   resp_p     : product at the FIFO head (0 when empty)
//   resp_id    : originating requester of the head (0 when empty)
//   busy       : at least one operation issued but not yet popped
module fp_mul_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1,
  parameter int RESP_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [32*NUM_REQ-1:0]      req_a,
  input  logic [32*NUM_REQ-1:0]      req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [31:0]                mul_a,
  output logic [31:0]                mul_b,
  input  logic [31:0]                mul_p,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [31:0]                resp_p,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic                       busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int AW    = $clog2(RESP_DEPTH);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  grant_id;
  logic             grant_found;
  logic             credit;
  logic             issue;
  logic             pop;
  logic [CNT_W-1:0] out_q, out_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic [MUL_LATENCY:0] tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]  tag_id_q [MUL_LATENCY+1];
  logic [ID_W-1:0]  tag_id_d [MUL_LATENCY+1];
  logic [31:0]      fifo_p_q [RESP_DEPTH];
  logic [31:0]      fifo_p_d [RESP_DEPTH];
  logic [ID_W-1:0]  fifo_id_q [RESP_DEPTH];
  logic [ID_W-1:0]  fifo_id_d [RESP_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_wr;

  assign resp_valid = (count_q != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_p     = resp_valid ? fifo_p_q[rd_ptr_q] : '0;
  assign resp_id    = resp_valid ? fifo_id_q[rd_ptr_q] : '0;
  assign busy       = (out_q != '0);
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  // The last tag stage lines up with mul_p for the same operation.
  assign fifo_wr    = tag_vld_q[MUL_LATENCY];

  // Round-robin search from ptr_q. A pop this cycle frees a slot, so it
  // counts as credit even when the outstanding count is at its limit.
  // Grants are gated by rst so req_ready stays low while reset is held.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
    credit    = (out_q < CNT_W'(RESP_DEPTH)) || pop;
    issue     = rst && credit && grant_found;
    req_ready = '0;
    if (issue) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    ptr_d   = ptr_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    out_d   = out_q;
    if (issue) begin
      ptr_d   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      mul_a_d = req_a[32*grant_id +: 32];
      mul_b_d = req_b[32*grant_id +: 32];
    end
    if (issue && !pop)      out_d = out_q + CNT_W'(1);
    else if (!issue && pop) out_d = out_q - CNT_W'(1);
  end

  always_comb begin
    tag_vld_d[0] = issue;
    tag_id_d[0]  = grant_id;
    for (int s = 1; s <= MUL_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  always_comb begin
    fifo_p_d  = fifo_p_q;
    fifo_id_d = fifo_id_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (fifo_wr) begin
      fifo_p_d[wr_ptr_q]  = mul_p;
      fifo_id_d[wr_ptr_q] = tag_id_q[MUL_LATENCY];
      wr_ptr_d            = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (fifo_wr && !pop)      count_d = count_q + CNT_W'(1);
    else if (!fifo_wr && pop) count_d = count_q - CNT_W'(1);
  end

  // Reset also clears the tag pipeline, so products still inside the
  // multiplier are never written back after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      out_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      tag_vld_q <= '0;
      for (int s = 0; s <= MUL_LATENCY; s++) tag_id_q[s] <= '0;
      for (int e = 0; e < RESP_DEPTH; e++) begin
        fifo_p_q[e]  <= '0;
        fifo_id_q[e] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      out_q     <= out_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      fifo_p_q  <= fifo_p_d;
      fifo_id_q <= fifo_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // A write into a full FIFO without a same-cycle pop means the credit check is broken.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(fifo_wr && (count_q == CNT_W'(RESP_DEPTH)) && !pop));
      assert (out_q <= CNT_W'(RESP_DEPTH));
    end
  end

endmodule
